// File: rtl/inst_player_if.sv
// Loader/core-facing bus of the instruction player: load strobes, replay control,
// the valid/ready issue port and status flags.
interface inst_player_if #(
  parameter int unsigned INST_W = 8,
  parameter int unsigned AW     = 4
);
  logic              wr_en;
  logic [INST_W-1:0] wr_data;
  logic              clr;
  logic              start;
  logic              stop;
  logic              inst_rdy;
  logic              inst_vld;
  logic [INST_W-1:0] inst_wd;
  logic              busy;
  logic              done;
  logic [AW:0]       count;
  logic              full;

  // Loader/core side drives controls and ready, observes issue port and status
  modport master (
    output wr_en, wr_data, clr, start, stop, inst_rdy,
    input  inst_vld, inst_wd, busy, done, count, full
  );

  modport slave (
    input  wr_en, wr_data, clr, start, stop, inst_rdy,
    output inst_vld, inst_wd, busy, done, count, full
  );
endinterface

// File: rtl/inst_player.sv
// Instruction sequencer: buffers up to DEPTH instructions and replays them over a
// valid/ready port with a GAP_CYC idle gap. Define INST_PLAYER_LOOP_EN for endless replay.
module inst_player #(
  parameter int unsigned INST_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned GAP_CYC = 4
) (
  input logic         clk,
  input logic         rst,
  inst_player_if.slave bus
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t            state, state_n;
  logic [AW-1:0]     rd_ptr, rd_ptr_n;
  logic [GW-1:0]     gap_cnt, gap_n;
  logic [CW-1:0]     count, count_n;
  logic              vld, vld_n;
  logic [INST_W-1:0] wd, wd_n;
  logic              busy, busy_n;
  logic              done, done_n;
  logic              full, full_n;

  logic [INST_W-1:0] mem [DEPTH];
  logic              we_c;
  logic              adv_c;
  logic              last_c;

  // Next-state and registered-output logic
  always_comb begin
    state_n  = state;
    rd_ptr_n = rd_ptr;
    gap_n    = gap_cnt;
    count_n  = count;
    vld_n    = vld;
    wd_n     = wd;
    done_n   = 1'b0;
    we_c     = 1'b0;
    adv_c    = 1'b0;
    last_c   = ({1'b0, rd_ptr} == (count - CW'(1)));

    case (state)
      IDLE: begin
        vld_n = 1'b0;
        if (bus.start) begin
          if (count != '0) begin
            state_n  = ISSUE;
            rd_ptr_n = '0;
            vld_n    = 1'b1;
            wd_n     = mem[0];
          end else begin
            done_n = 1'b1;
          end
        end else if (bus.clr) begin
          count_n = '0;
        end else if (bus.wr_en && !full) begin
          we_c    = 1'b1;
          count_n = count + CW'(1);
        end
      end

      ISSUE: begin
        // stop beats the handshake; the word still counts as taken by the core
        if (bus.stop) begin
          state_n = IDLE;
          vld_n   = 1'b0;
        end else if (vld && bus.inst_rdy) begin
          if (GAP_CYC > 0) begin
            state_n = GAP;
            vld_n   = 1'b0;
            gap_n   = GW'(GAP_CYC - 1);
          end else begin
            adv_c = 1'b1;
          end
        end
      end

      GAP: begin
        if (bus.stop) begin
          state_n = IDLE;
          vld_n   = 1'b0;
        end else if (gap_cnt == '0) begin
          adv_c = 1'b1;
        end else begin
          gap_n = gap_cnt - GW'(1);
        end
      end

      default: begin
        state_n = IDLE;
        vld_n   = 1'b0;
      end
    endcase

    // Move to the next entry, or finish the pass after the last one
    if (adv_c) begin
      if (last_c) begin
        done_n = 1'b1;
`ifdef INST_PLAYER_LOOP_EN
        state_n  = ISSUE;
        rd_ptr_n = '0;
        vld_n    = 1'b1;
        wd_n     = mem[0];
`else
        state_n  = IDLE;
        vld_n    = 1'b0;
`endif
      end else begin
        state_n  = ISSUE;
        rd_ptr_n = rd_ptr + AW'(1);
        vld_n    = 1'b1;
        wd_n     = mem[rd_ptr + AW'(1)];
      end
    end

    busy_n = (state_n != IDLE);
    full_n = (count_n == CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      gap_cnt <= '0;
      count   <= '0;
      vld     <= 1'b0;
      wd      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      full    <= 1'b0;
    end else begin
      state   <= state_n;
      rd_ptr  <= rd_ptr_n;
      gap_cnt <= gap_n;
      count   <= count_n;
      vld     <= vld_n;
      wd      <= wd_n;
      busy    <= busy_n;
      done    <= done_n;
      full    <= full_n;
    end
  end

  // Instruction storage; contents survive reset and replay
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[count[AW-1:0]] <= bus.wr_data;
    end
  end

  assign bus.inst_vld = vld;
  assign bus.inst_wd  = wd;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.count    = count;
  assign bus.full     = full;

endmodule

// File: tb/tb_inst_player.sv
// Self-checking bench for inst_player: directed scenarios plus randomized loads and
// ready patterns, compared against a queue-based model of load capacity and replay order.
module tb_inst_player;
  localparam int unsigned INST_W  = 8;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned GAP_CYC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_player_if #(.INST_W(INST_W), .AW(AW)) bus ();

  inst_player #(.INST_W(INST_W), .DEPTH(DEPTH), .AW(AW), .GAP_CYC(GAP_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [INST_W-1:0] model_q [$];
  logic [INST_W-1:0] acc_q   [$];
  int                acc_cyc [$];
  int                cyc       = 0;
  int                done_cnt  = 0;
  int                vld_seen  = 0;
  int                stall_cnt = 0;
  int                stall_bad = 0;
  bit                rdy_rand  = 1'b0;
  logic              prev_stall = 1'b0;
  logic [INST_W-1:0] prev_wd;

  // Observer on the falling edge: accepted words, done pulses, stall stability
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      cyc++;
      if (prev_stall) begin
        stall_cnt++;
        if (!(bus.inst_vld === 1'b1 && bus.inst_wd === prev_wd)) stall_bad++;
      end
      if (bus.inst_vld === 1'b1) vld_seen++;
      if (bus.done === 1'b1) done_cnt++;
      if (bus.inst_vld === 1'b1 && bus.inst_rdy === 1'b1) begin
        acc_q.push_back(bus.inst_wd);
        acc_cyc.push_back(cyc);
      end
      prev_stall = bus.inst_vld && !bus.inst_rdy && !bus.stop;
      prev_wd    = bus.inst_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_rand) bus.inst_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic load(input logic [INST_W-1:0] w);
    bus.wr_en   = 1'b1;
    bus.wr_data = w;
    step();
    bus.wr_en = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(w);
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic clear_buf();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    model_q.delete();
  endtask

  task automatic start_replay();
    acc_q.delete();
    acc_cyc.delete();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int tgt;
    int n;
    tgt = done_cnt + 1;
    n   = 0;
    while (done_cnt < tgt && n < max) begin
      step();
      n++;
    end
    chk("done_wait", 32'(done_cnt >= tgt), 32'd1);
  endtask

  task automatic wait_acc(input int n, input int max);
    int k;
    k = 0;
    while (acc_q.size() < n && k < max) begin
      step();
      k++;
    end
    chk("acc_wait", 32'(acc_q.size() >= n), 32'd1);
  endtask

  task automatic check_replay(input string tag);
    chk({tag, "_len"}, 32'(acc_q.size()), 32'(model_q.size()));
    for (int i = 0; i < model_q.size() && i < acc_q.size(); i++)
      chk(tag, 32'(acc_q[i]), 32'(model_q[i]));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vld"},   32'(bus.inst_vld), 32'd0);
    chk({tag, "_wd"},    32'(bus.inst_wd),  32'd0);
    chk({tag, "_busy"},  32'(bus.busy),     32'd0);
    chk({tag, "_done"},  32'(bus.done),     32'd0);
    chk({tag, "_count"}, 32'(bus.count),    32'd0);
    chk({tag, "_full"},  32'(bus.full),     32'd0);
  endtask

  initial begin
    logic [INST_W-1:0] vec [6];
    int d0;
    int v0;
    int n;
    int k;
    vec = '{8'h04, 8'h00, 8'h13, 8'h86, 8'h4B, 8'hC0};

    bus.wr_en = 1'b0; bus.wr_data = '0; bus.clr = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0;  bus.inst_rdy = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    step();

`ifdef INST_PLAYER_LOOP_EN
    // Endless replay of three entries, done at each wrap, exit by stop
    for (int i = 0; i < 3; i++) load(INST_W'($urandom));
    bus.inst_rdy = 1'b1;
    d0 = done_cnt;
    start_replay();
    wait_acc(10, 200);
    for (int i = 0; i < 10 && i < acc_q.size(); i++)
      chk("loop_seq", 32'(acc_q[i]), 32'(model_q[i % 3]));
    chk("loop_wraps", 32'(done_cnt - d0), 32'd3);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("loop_stop_busy", 32'(bus.busy), 32'd0);
    chk("loop_stop_vld", 32'(bus.inst_vld), 32'd0);
    d0 = done_cnt;
    repeat (10) step();
    chk("loop_no_done", 32'(done_cnt - d0), 32'd0);
`else
    // Six-word load, paced replay with ready held high
    foreach (vec[i]) load(vec[i]);
    chk("load6_count", 32'(bus.count), 32'd6);
    chk("load6_full", 32'(bus.full), 32'd0);
    bus.inst_rdy = 1'b1;
    d0 = done_cnt;
    start_replay();
    chk("first_vld", 32'(bus.inst_vld), 32'd1);
    chk("first_wd", 32'(bus.inst_wd), 32'(vec[0]));
    wait_done(200);
    check_replay("seq6");
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("gap_period", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(GAP_CYC + 1));
    repeat (10) step();
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("retain_count", 32'(bus.count), 32'd6);
    chk("end_busy", 32'(bus.busy), 32'd0);

    // Ready withheld on the second issue
    start_replay();
    wait_acc(1, 50);
    bus.inst_rdy = 1'b0;
    k = 0;
    while (bus.inst_vld !== 1'b1 && k < 50) begin step(); k++; end
    repeat (10) step();
    chk("stall_vld", 32'(bus.inst_vld), 32'd1);
    chk("stall_wd", 32'(bus.inst_wd), 32'(vec[1]));
    chk("stall_acc", 32'(acc_q.size()), 32'd1);
    bus.inst_rdy = 1'b1;
    wait_done(200);
    check_replay("stall_seq");

    // stop in the gap after the third issue, then full restart
    start_replay();
    wait_acc(3, 100);
    step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop_busy", 32'(bus.busy), 32'd0);
    chk("stop_vld", 32'(bus.inst_vld), 32'd0);
    d0 = done_cnt;
    repeat (10) step();
    chk("stop_no_done", 32'(done_cnt - d0), 32'd0);
    chk("stop_acc", 32'(acc_q.size()), 32'd3);
    start_replay();
    wait_done(200);
    check_replay("restart_seq");

    // start on an empty buffer
    clear_buf();
    chk("clr_count", 32'(bus.count), 32'd0);
    v0 = vld_seen;
    d0 = done_cnt;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("empty_done", 32'(bus.done), 32'd1);
    step();
    chk("empty_done_pulse", 32'(bus.done), 32'd0);
    repeat (5) step();
    chk("empty_no_vld", 32'(vld_seen - v0), 32'd0);
    chk("empty_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Overfill, then replay with random ready
    for (int i = 0; i < DEPTH + 2; i++) load(INST_W'($urandom));
    chk("over_count", 32'(bus.count), 32'(DEPTH));
    chk("over_full", 32'(bus.full), 32'd1);
    rdy_rand = 1'b1;
    start_replay();
    wait_done(2000);
    check_replay("over_seq");

    // Random lengths; load/clear attempts while busy must be ignored
    repeat (4) begin
      rdy_rand = 1'b0;
      clear_buf();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) load(INST_W'($urandom));
      rdy_rand = 1'b1;
      start_replay();
      bus.wr_en   = 1'b1;
      bus.wr_data = INST_W'($urandom);
      bus.clr     = 1'b1;
      step();
      bus.wr_en = 1'b0;
      bus.clr   = 1'b0;
      wait_done(2000);
      check_replay("rand_seq");
      chk("rand_count", 32'(bus.count), 32'(model_q.size()));
    end

    // Asynchronous reset while an issue is pending
    rdy_rand = 1'b0;
    bus.inst_rdy = 1'b0;
    start_replay();
    step();
    chk("pre_rst_vld", 32'(bus.inst_vld), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("rst_issue");
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_count", 32'(bus.count), 32'd0);
`endif

    chk("stall_hold", 32'(stall_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
